product_accumulator: RTL and testbench
======================================

# product_accumulator

Framed accumulator that consumes 2n-bit products from the signed/unsigned multiplier stage and sums them into a widened register. Each product is sign- or zero-extended according to its own signedness flag. Sticky overflow detection runs over each frame. The frame total is presented on a single-entry output register with valid/ready handshake. It sits directly downstream of the multiplier in the MAC datapath.

## Interface
- n, 8: multiplier operand width; products are 2n bits
- g, 4: accumulator guard bits; accumulator width aw = 2n + g
- cw, 6: beat-counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  product beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_prod  in  2n  product bits
- in_signed  in  1  1: in_prod is two's complement; 0: unsigned
- in_last  in  1  final beat of frame
- out_valid  out  1  frame result held
- out_ready  in  1  result consumed when out_valid & out_ready
- out_sum  out  aw  frame total (two's complement if any beat was signed)
- out_count  out  cw  beats in frame, saturating at all-ones
- out_ovf  out  1  overflow occurred anywhere in the frame

## Operation
- Extension: in_signed=1 sign-extends in_prod to aw; in_signed=0 zero-extends.
- Add is done at aw+1 bits.
- Overflow test for a signed beat: bits aw and aw-1 of the extended sum differ.
- Overflow test for an unsigned beat: carry out of bit aw-1.
- Overflow is judged by the accepted beat's own in_signed.
- Internal state:
  - acc[aw-1:0], cnt[cw-1:0], ovf (sticky within a frame).
  - Output register: out_sum, out_count, out_ovf, out_valid.
- Accepted non-last beat: acc ← acc+ext; cnt ← sat(cnt+1); ovf ← ovf | beat_ovf.
- Accepted last beat:
  - Output register ← (acc+ext, sat(cnt+1), ovf | beat_ovf); out_valid ← 1.
  - acc, cnt and ovf clear to 0.
- Single-beat frames are legal: in_last on the first beat.
- in_ready = ~out_valid | out_ready, applied to every beat, not only last beats.
- Result consumed without a new last beat: out_valid ← 0; out_sum/out_count/out_ovf hold their old values.
- Result consumed in the same cycle as a new last beat is accepted: the new result loads and out_valid stays 1.
- Reset:
  - acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- Reset mid-frame discards the partial frame and any unconsumed result.

## Timing
- Latency: a last beat accepted at edge k gives out_valid=1 and a valid result from edge k onward (visible in cycle k+1).
- Throughput: one beat per cycle while out_ready=1 or out_valid=0.
- in_ready is combinational from out_valid and out_ready only, never from in_valid.
- While out_valid=1 & out_ready=0:
  - out_sum, out_count and out_ovf are stable.
  - in_ready=0, and the source must hold its beat.

## Configuration
- PRODUCT_ACCUMULATOR_SATURATE_EN defined:
  - A beat that overflows loads the clamp value instead of the wrapped sum.
  - Signed clamp: max (0 followed by ones) or min (1 followed by zeros), chosen by bit aw of the sum.
  - Unsigned clamp: all-ones.
  - out_ovf is still reported.
- Undefined: the sum wraps modulo 2^aw; out_ovf is still reported.

## Structure
- Shared package mac_pkg:
  - Default n, g, cw as localparams.
  - Function ext_prod(prod, is_signed).
  - Typedef of the result struct {sum, count, ovf}.
- Sub-module acc_add_ovf (combinational): takes acc, in_prod and in_signed; returns next_acc and beat_ovf. The saturation macro is handled inside it.
- Top level: accumulator registers, beat counter, output register and handshake.

## Test plan
All scenarios use n=4, g=4, cw=6, so aw=12.

- Signed frame: 8'hD6 (-42) then 8'h0F (15, last), both signed → out_sum=12'hFE5 (-27), out_count=2, out_ovf=0, one cycle after the last beat.
- Unsigned frame: 19 beats of 8'hE1 (225), last on beat 19 → out_ovf=1, out_count=19.
  - Without the macro: out_sum=12'h0B3.
  - With the macro: out_sum=12'hFFF.
- Backpressure: result pending with out_ready=0 for 5 cycles, next frame offered → in_ready=0 and out_sum stable all 5 cycles; after out_ready=1, the next frame proceeds with no beat lost.
- Simultaneous event: out_valid=1, out_ready=1, and a single-beat frame 8'h07 (unsigned, last) accepted in the same cycle → out_valid stays 1 and out_sum=12'h007, out_count=1 next cycle.
- Reset mid-frame: two beats 8'h10 accepted, rst for 1 cycle, then 8'h0F unsigned last → out_sum=12'h00F, out_count=1, out_ovf=0; during reset out_valid=0.
- Signed min product: 8'h40 (-8*-8=64) ×32 beats, signed → sum 2048 overflows → out_ovf=1.
  - Without the macro: out_sum=12'h800.
  - With the macro: out_sum=12'h7FF.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared MAC datapath package: default widths, product extension helper and result record.
package mac_pkg;

  localparam int N_DEF  = 8;
  localparam int G_DEF  = 4;
  localparam int CW_DEF = 6;
  localparam int AW_DEF = 2 * N_DEF + G_DEF;

  typedef struct packed {
    logic [AW_DEF-1:0] sum;
    logic [CW_DEF-1:0] count;
    logic              ovf;
  } mac_result_t;

  // Extends the low pw bits of prod to 64 bits; callers slice the width they need.
  function automatic logic [63:0] ext_prod(input logic [63:0] prod, input logic is_signed,
                                           input int pw);
    logic [63:0] r;
    logic        fill;
    fill = is_signed & prod[pw-1];
    for (int i = 0; i < 64; i++) begin
      r[i] = (i < pw) ? prod[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product beat stream in, frame result out; master drives beats and accepts results.
interface product_accumulator_if #(
  parameter int N  = 8,
  parameter int G  = 4,
  parameter int CW = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2*N-1:0]    in_prod;
  logic              in_signed;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [2*N+G-1:0]  out_sum;
  logic [CW-1:0]     out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_signed, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_signed, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/product_accumulator_acc_add_ovf.sv
// Combinational accumulate step with per-beat overflow.
// Build option PRODUCT_ACCUMULATOR_SATURATE_EN clamps overflowing sums instead of wrapping.
module acc_add_ovf
  import mac_pkg::*;
#(
  parameter int N = 8,
  parameter int G = 4
) (
  input  logic [2*N+G-1:0] acc_i,
  input  logic [2*N-1:0]   prod_i,
  input  logic             is_signed_i,
  output logic [2*N+G-1:0] next_acc_o,
  output logic             beat_ovf_o
);
  localparam int AW = 2 * N + G;

  logic [63:0] ext_w;
  logic [AW:0] acc_x;
  logic [AW:0] sum_w;

  assign ext_w = ext_prod(64'(prod_i), is_signed_i, 2 * N);
  // The accumulator is read with the beat's own signedness at aw+1 bits.
  assign acc_x = {is_signed_i & acc_i[AW-1], acc_i};
  assign sum_w = acc_x + ext_w[AW:0];

  assign beat_ovf_o = is_signed_i ? (sum_w[AW] ^ sum_w[AW-1]) : sum_w[AW];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  logic [AW-1:0] clamp_w;
  always_comb begin
    clamp_w = '1;
    if (is_signed_i) begin
      clamp_w = sum_w[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end
  assign next_acc_o = beat_ovf_o ? clamp_w : sum_w[AW-1:0];
`else
  assign next_acc_o = sum_w[AW-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Framed product accumulator with sticky overflow and a single-entry result register.
// Build option PRODUCT_ACCUMULATOR_SATURATE_EN selects clamping in acc_add_ovf.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int G  = G_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);
  localparam int AW = 2 * N + G;

  typedef struct packed {
    logic [AW-1:0] sum;
    logic [CW-1:0] count;
    logic          ovf;
  } result_t;

  logic [AW-1:0] acc_q, acc_d, next_acc;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ovf_q, ovf_d, beat_ovf;
  logic          out_valid_q, out_valid_d;
  result_t       res_q, res_d;
  logic          in_ready;
  logic          accept;

  acc_add_ovf #(.N(N), .G(G)) u_add (
    .acc_i       (acc_q),
    .prod_i      (bus.in_prod),
    .is_signed_i (bus.in_signed),
    .next_acc_o  (next_acc),
    .beat_ovf_o  (beat_ovf)
  );

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (bus.in_last) begin
        // A new result may replace one consumed on this very edge.
        res_d       = '{sum: next_acc, count: cnt_inc, ovf: ovf_q | beat_ovf};
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = next_acc;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | beat_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = res_q.sum;
  assign bus.out_count = res_q.count;
  assign bus.out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator (n=4, g=4, cw=6): directed frames then random traffic
// against an integer-arithmetic frame model.
module tb_product_accumulator;
  localparam int N    = 4;
  localparam int G    = 4;
  localparam int CW   = 6;
  localparam int AW   = 2 * N + G;
  localparam int PW   = 2 * N;
  localparam int MOD  = 1 << AW;
  localparam int PMOD = 1 << PW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  product_accumulator_if #(.N(N), .G(G), .CW(CW)) bus ();

  product_accumulator #(.N(N), .G(G), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Frame model: running total as a plain integer value, results as an output record.
  int m_acc, m_cnt, m_sum, m_count;
  bit m_ovf, m_ov, m_oovf;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic beat_model(input int prod, input bit sgn, output int res, output bit o);
    int a, p, s, sat;
    if (sgn) begin
      a = (m_acc >= MOD / 2) ? m_acc - MOD : m_acc;
      p = (prod >= PMOD / 2) ? prod - PMOD : prod;
      s = a + p;
      o = (s > MOD / 2 - 1) || (s < -(MOD / 2));
      sat = (s > 0) ? MOD / 2 - 1 : MOD / 2;
    end else begin
      s = m_acc + prod;
      o = s > MOD - 1;
      sat = MOD - 1;
    end
    res = ((s % MOD) + MOD) % MOD;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    if (o) res = sat;
`endif
  endtask

  // Entered on a falling edge: drive, check in_ready, advance one clock, check outputs.
  task automatic step(input bit v, input int prod, input bit sgn, input bit last,
                      input bit ordy, output bit acc);
    int res;
    bit o;
    bus.in_valid  = v;
    bus.in_prod   = PW'(prod);
    bus.in_signed = sgn;
    bus.in_last   = last;
    bus.out_ready = ordy;
    #1;
    chk("in_ready", int'(bus.in_ready), int'(!m_ov || ordy));
    acc = v && (!m_ov || ordy);
    if (rst) begin
      model_clear();
      m_ov = 0; m_sum = 0; m_count = 0; m_oovf = 0;
      acc = 0;
    end else begin
      if (m_ov && ordy) m_ov = 0;
      if (acc) begin
        beat_model(prod, sgn, res, o);
        if (last) begin
          m_sum = res;
          m_count = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
          m_oovf = m_ovf | o;
          m_ov = 1;
          model_clear();
        end else begin
          m_acc = res;
          m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
          m_ovf = m_ovf | o;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", int'(bus.out_valid), int'(m_ov));
    chk("out_sum", int'(bus.out_sum), m_sum);
    chk("out_count", int'(bus.out_count), m_count);
    chk("out_ovf", int'(bus.out_ovf), int'(m_oovf));
  endtask

  initial begin
    bit a;
    bit have, v, s, l, ordy;
    int p;
    int held;

    rst = 1'b1;
    bus.in_valid = 0; bus.in_prod = '0; bus.in_signed = 0; bus.in_last = 0; bus.out_ready = 0;
    model_clear();
    m_ov = 0; m_sum = 0; m_count = 0; m_oovf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(0, 0, 0, 0, 0, a);
    rst = 1'b0;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_sum", int'(bus.out_sum), 0);

    // Signed two-beat frame
    step(1, 'hD6, 1, 0, 1, a);
    step(1, 'h0F, 1, 1, 1, a);
    chk("sgn_valid", int'(bus.out_valid), 1);
    chk("sgn_sum", int'(bus.out_sum), 'hFE5);
    chk("sgn_count", int'(bus.out_count), 2);
    chk("sgn_ovf", int'(bus.out_ovf), 0);

    // Unsigned 19-beat frame that overflows
    for (int i = 0; i < 19; i++) step(1, 'hE1, 0, i == 18, 1, a);
    chk("uns_ovf", int'(bus.out_ovf), 1);
    chk("uns_count", int'(bus.out_count), 19);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("uns_sum", int'(bus.out_sum), 'hFFF);
`else
    chk("uns_sum", int'(bus.out_sum), 'h0B3);
`endif

    // Backpressure: held result, next frame stalled
    held = int'(bus.out_sum);
    for (int i = 0; i < 5; i++) begin
      step(1, 'h05, 0, 0, 0, a);
      chk("bp_accept", int'(a), 0);
      chk("bp_sum", int'(bus.out_sum), held);
    end
    step(1, 'h05, 0, 0, 1, a);
    step(1, 'h03, 0, 1, 1, a);
    chk("bp_next_sum", int'(bus.out_sum), 'h008);
    chk("bp_next_count", int'(bus.out_count), 2);

    // Consume and load a single-beat frame in the same cycle
    step(1, 'h07, 0, 1, 1, a);
    chk("sim_valid", int'(bus.out_valid), 1);
    chk("sim_sum", int'(bus.out_sum), 'h007);
    chk("sim_count", int'(bus.out_count), 1);

    // Reset in the middle of a frame
    step(1, 'h10, 0, 0, 1, a);
    step(1, 'h10, 0, 0, 1, a);
    rst = 1'b1;
    step(0, 0, 0, 0, 1, a);
    chk("rst_mid_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    step(1, 'h0F, 0, 1, 1, a);
    chk("rst_mid_sum", int'(bus.out_sum), 'h00F);
    chk("rst_mid_count", int'(bus.out_count), 1);
    chk("rst_mid_ovf", int'(bus.out_ovf), 0);

    // Signed 32-beat frame reaching +2048
    for (int i = 0; i < 32; i++) step(1, 'h40, 1, i == 31, 1, a);
    chk("smin_ovf", int'(bus.out_ovf), 1);
    chk("smin_count", int'(bus.out_count), 32);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("smin_sum", int'(bus.out_sum), 'h7FF);
`else
    chk("smin_sum", int'(bus.out_sum), 'h800);
`endif

    // Random traffic; a stalled beat is held until accepted
    have = 0; v = 0; p = 0; s = 0; l = 0;
    for (int i = 0; i < 600; i++) begin
      if (!have) begin
        v = $urandom_range(0, 3) != 0;
        p = int'($urandom_range(0, PMOD - 1));
        s = $urandom_range(0, 1) == 1;
        l = $urandom_range(0, 5) == 0;
      end
      ordy = $urandom_range(0, 2) != 0;
      step(v, p, s, l, ordy, a);
      have = v && !a;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
